// File: rtl/fpadd_result_buf_if.sv
// Handshake and status bundle between the fpadd result buffer and its environment.
// The slave side is the buffer; the master side is upstream plus consumer.
interface fpadd_result_buf_if #(
   parameter int CW = 3
);
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_result;
   logic [4:0]    in_flags;
   logic          in_denorm;
   logic [3:0]    in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_result;
   logic [4:0]    out_flags;
   logic          out_denorm;
   logic [3:0]    out_tag;
   logic          flags_clr;
   logic [4:0]    sticky_flags;
   logic [CW-1:0] count;
   logic [31:0]   op_count;

   modport slave (
      input  in_valid, in_result, in_flags, in_denorm, in_tag, out_ready, flags_clr,
      output in_ready, out_valid, out_result, out_flags, out_denorm, out_tag,
             sticky_flags, count, op_count
   );

   modport master (
      output in_valid, in_result, in_flags, in_denorm, in_tag, out_ready, flags_clr,
      input  in_ready, out_valid, out_result, out_flags, out_denorm, out_tag,
             sticky_flags, count, op_count
   );
endinterface

// File: rtl/fpadd_result_buf.sv
// Registered in-order FIFO behind the fpadd unit, with a sticky exception-flag
// accumulator and a wrapping count of accepted operations.
module fpadd_result_buf #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic                clk,
   input logic                reset,
   fpadd_result_buf_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  flags;
      logic        denorm;
      logic [3:0]  tag;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CW-1:0]   count_q, count_d;
   logic [4:0]      sticky_q, sticky_d;
   logic [31:0]     op_count_q, op_count_d;

   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   entry_t head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   // A full buffer refuses a push even when the head is popped that cycle.
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;

   // NOTE: every variable gets a default before any conditional update so no latch is inferred.
   always_comb begin
      mem_d      = mem_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      op_count_d = op_count_q;
      if (push) begin
         mem_d[wp_q] = '{result: bus.in_result, flags: bus.in_flags,
                         denorm: bus.in_denorm, tag: bus.in_tag};
         wp_d        = wp_q + AW'(1);
         op_count_d  = op_count_q + 32'd1;
      end
      if (pop) begin
         rp_d = rp_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      sticky_d = (bus.flags_clr ? 5'b0 : sticky_q) | (push ? bus.in_flags : 5'b0);
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: storage is reset too, because the head of an empty buffer is still visible on out_*.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         sticky_q   <= '0;
         op_count_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         sticky_q   <= sticky_d;
         op_count_q <= op_count_d;
      end
   end

   assign head             = mem_q[rp_q];
   assign bus.in_ready     = ~full & ~reset;
   assign bus.out_valid    = ~empty;
   assign bus.out_result   = head.result;
   assign bus.out_flags    = head.flags;
   assign bus.out_denorm   = head.denorm;
   assign bus.out_tag      = head.tag;
   assign bus.sticky_flags = sticky_q;
   assign bus.count        = count_q;
   assign bus.op_count     = op_count_q;
endmodule
